// File: rtl/di_bus_arbiter_pkg.sv
// Shared definitions for the device-interface bus arbiter.
//   BusW        : width of every address/data path on the device-interface port
//   arb_state_e : transaction sequencer states
package di_bus_arbiter_pkg;

  localparam int unsigned BusW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StSettle,
    StWait,
    StDone
  } arb_state_e;

endpackage

// File: rtl/di_rr_picker.sv
// Combinational round-robin picker.
//   pending_i : request vector
//   ptr_i     : highest-priority index this round
//   winner_o  : one-hot winner (0 when nothing pending)
//   idx_o     : binary index of the winner
//   valid_o   : any request pending
module di_rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    pending_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    winner_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    logic [IdxW-1:0] j;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = '0;
    // Scan from the pointer upward, wrapping; the first hit wins.
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N);
      if (!valid_o && pending_i[j]) begin
        valid_o     = 1'b1;
        winner_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/di_bus_arbiter.sv
// Round-robin arbiter sharing one device-interface register port among NREQ requesters.
// One transaction at a time: strobe, optional settle window, wait for rdwr_ready or timeout,
// then a one-cycle ack (plus err on timeout) to the owner.
//   clk, reset                     : clock, asynchronous active-high reset
//   req_read/req_write             : per-requester level requests (read wins if both)
//   req_ep_addr/req_reg_addr/req_wdata : packed 16-bit fields, requester i at [16i+15:16i]
//   req_ack/req_err                : one-cycle completion / timeout pulses to the owner
//   rdata                          : captured read data, valid with req_ack
//   grant                          : one-hot owner, 0 when idle
//   diEpAddr/diRegAddr/diRegDataIn : bus address/data, held until the next grant
//   diRead/diWrite                 : one-cycle strobes
//   rdwr_ready/diRegDataOut        : endpoint completion and read data
module di_bus_arbiter
  import di_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_read,
  input  logic [NREQ-1:0]      req_write,
  input  logic [16*NREQ-1:0]   req_ep_addr,
  input  logic [16*NREQ-1:0]   req_reg_addr,
  input  logic [16*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic [BusW-1:0]      rdata,
  output logic [NREQ-1:0]      grant,
  output logic [BusW-1:0]      diEpAddr,
  output logic [BusW-1:0]      diRegAddr,
  output logic [BusW-1:0]      diRegDataIn,
  output logic                 diRead,
  output logic                 diWrite,
  input  logic                 rdwr_ready,
  input  logic [BusW-1:0]      diRegDataOut
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            op_read_q, op_read_d;
  logic            err_q, err_d;
  logic [BusW-1:0] ep_q, ep_d;
  logic [BusW-1:0] reg_q, reg_d;
  logic [BusW-1:0] wd_q, wd_d;
  logic [BusW-1:0] rdata_q, rdata_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     cnt_inc;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] pick_winner;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  assign pending = req_read | req_write;
  assign cnt_inc = 32'(cnt_q) + 32'd1;

  di_rr_picker #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_picker (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .winner_o  (pick_winner),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    op_read_d = op_read_q;
    err_d     = err_q;
    ep_d      = ep_q;
    reg_d     = reg_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          owner_d = pick_idx;
          err_d   = 1'b0;
          cnt_d   = '0;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_winner[i]) begin
              ep_d      = req_ep_addr[BusW*i +: BusW];
              reg_d     = req_reg_addr[BusW*i +: BusW];
              wd_d      = req_wdata[BusW*i +: BusW];
              op_read_d = req_read[i];  // read takes precedence when both are high
            end
          end
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? StWait : StSettle;
      end
      StSettle: begin
        // rdwr_ready may still reflect the previous access here; ignore it.
        if (cnt_inc >= SETTLE) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWait: begin
        if (rdwr_ready) begin
          rdata_d = diRegDataOut;
          state_d = StDone;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (cnt_inc >= TIMEOUT) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Owner drops to lowest priority for the next round.
        ptr_d   = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      op_read_q <= 1'b0;
      err_q     <= 1'b0;
      ep_q      <= '0;
      reg_q     <= '0;
      wd_q      <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      op_read_q <= op_read_d;
      err_q     <= err_d;
      ep_q      <= ep_d;
      reg_q     <= reg_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign diEpAddr    = ep_q;
  assign diRegAddr   = reg_q;
  assign diRegDataIn = wd_q;
  assign diRead      = (state_q == StStrobe) &&  op_read_q;
  assign diWrite     = (state_q == StStrobe) && !op_read_q;
  assign req_ack     = (state_q == StDone) ? grant_q : '0;
  assign req_err     = (state_q == StDone && err_q) ? grant_q : '0;
  assign rdata       = rdata_q;

endmodule
